// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder.
//  - RISC-V load/store funct3 encodings.
//  - Responder FSM state encoding.
//  - Latched request record.
//  - Helper that tells whether a funct3/direction pair is a legal access.
package data_mem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Unsigned loads exist only as loads; stores accept B/H/W only.
  function automatic logic f3_legal(input logic write, input logic [2:0] funct3);
    logic ok;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane alignment for the data memory responder (purely combinational).
// Ports:
//  addr_lo  in   2   byte offset within the word (addr[1:0])
//  funct3   in   3   access size / extension selector
//  wdata    in   32  store data, lane-0 aligned
//  rword    in   32  word read from the data array
//  wmask    out  4   byte write enables for a store
//  wword    out  32  store data replicated onto the selected lanes
//  rdata    out  32  extracted and sign/zero extended load result
module data_mem_responder_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store side: replicate the data across lanes so the mask alone picks the target lanes.
  always_comb begin
    wmask = 4'b0000;
    wword = 32'h0000_0000;
    case (funct3)
      F3_B: begin
        wmask = 4'b0001 << addr_lo;
        wword = {4{wdata[7:0]}};
      end
      F3_H: begin
        wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      F3_W: begin
        wmask = 4'b1111;
        wword = wdata;
      end
      default: begin
        wmask = 4'b0000;
        wword = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then extend according to funct3.
  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      2'd3:    byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    half_s = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_B:    rdata = {{24{byte_s[7]}}, byte_s};
      F3_H:    rdata = {{16{half_s[15]}}, half_s};
      F3_W:    rdata = rword;
      F3_BU:   rdata = {24'h00_0000, byte_s};
      F3_HU:   rdata = {16'h0000, half_s};
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the MEM-stage load/store interface.
// Accepts one request at a time, commits it to a word-organised data array after a
// fixed latency and returns a one-cycle response.
// Ports:
//  clk        in   1   clock, all state updates on posedge
//  rst        in   1   asynchronous active-low reset
//  reqValid   in   1   request present
//  reqWrite   in   1   1 = store, 0 = load
//  reqFunct3  in   3   access size / extension
//  reqAddr    in   32  byte address
//  reqWData   in   32  store data, lane-0 aligned
//  reqReady   out  1   responder can accept this cycle
//  respValid  out  1   one-cycle response pulse
//  respRData  out  32  load result (0 for stores and errors)
//  respErr    out  1   misaligned, out-of-range or illegal access
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [2:0]  reqFunct3,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  output logic        reqReady,
  output logic        respValid,
  output logic [31:0] respRData,
  output logic        respErr
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_C    = 32'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD_C = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  resp_state_e state_r, state_nxt_s;
  logic [3:0]  cnt_r;
  mem_req_t    req_r;
  mem_req_t    in_req_s;
  mem_req_t    cmd_s;
  logic        ready_r, valid_r, err_r;
  logic [31:0] rdata_r;
  logic        acc_s, enter_resp_s, ready_nxt_s;
  logic        err_s, misalign_s, range_err_s, we_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0] rword_s, ldata_s, wword_s;
  logic [3:0]  wmask_s;
  logic [31:0] mem_r [DEPTH_WORDS];

  assign acc_s    = reqValid & ready_r;
  assign in_req_s = '{write: reqWrite, funct3: reqFunct3, addr: reqAddr, wdata: reqWData};

  // With LATENCY=1 the commit edge is the accept edge, so the live request is used
  // directly; otherwise the latched copy is committed.
  assign cmd_s = (LATENCY == 1) ? in_req_s : req_r;

  assign reqReady  = ready_r;
  assign respValid = valid_r;
  assign respRData = rdata_r;
  assign respErr   = err_r;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, RESP: begin
        if (acc_s) begin
          state_nxt_s = (LATENCY == 1) ? RESP : WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: commit strobe and the ready value for the next cycle.
  always_comb begin
    enter_resp_s = (state_nxt_s == RESP);
    ready_nxt_s  = (state_nxt_s != WAIT);
  end

  // Access checks on the request being committed.
  always_comb begin
    case (cmd_s.funct3)
      F3_H, F3_HU: misalign_s = cmd_s.addr[0];
      F3_W:        misalign_s = (cmd_s.addr[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
    range_err_s = ({2'b00, cmd_s.addr[31:2]} >= DEPTH_C);
    err_s       = ~f3_legal(cmd_s.write, cmd_s.funct3) | misalign_s | range_err_s;
    idx_s       = cmd_s.addr[IDX_W+1:2];
    if (err_s) begin
      rword_s = 32'h0000_0000;
    end else begin
      rword_s = mem_r[idx_s];
    end
    we_s = enter_resp_s & cmd_s.write & ~err_s;
  end

  data_mem_responder_lane_align u_lane_align (
    .addr_lo (cmd_s.addr[1:0]),
    .funct3  (cmd_s.funct3),
    .wdata   (cmd_s.wdata),
    .rword   (rword_s),
    .wmask   (wmask_s),
    .wword   (wword_s),
    .rdata   (ldata_s)
  );

  // Request latch and latency down-counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_r <= '0;
      cnt_r <= 4'd0;
    end else if (acc_s) begin
      req_r <= in_req_s;
      cnt_r <= CNT_LOAD_C;
    end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
      cnt_r <= cnt_r - 4'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Registered response and ready; ready stays low through reset and for the first
  // cycle after release, after which it tracks "not waiting".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= ready_nxt_s;
      valid_r <= enter_resp_s;
      err_r   <= enter_resp_s & err_s;
      rdata_r <= (enter_resp_s && !err_s && !cmd_s.write) ? ldata_s : 32'h0000_0000;
    end
  end

  // Data array write port; contents are intentionally not reset. A request dropped
  // by reset never reaches RESP, so its store is never committed.
  always_ff @(posedge clk) begin
    if (we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // LATENCY=2 instance
  logic        reqValid = 1'b0, reqWrite = 1'b0;
  logic [2:0]  reqFunct3 = 3'd0;
  logic [31:0] reqAddr = 32'd0, reqWData = 32'd0;
  logic        reqReady, respValid, respErr;
  logic [31:0] respRData;

  // LATENCY=1 instance
  logic        v1 = 1'b0, w1 = 1'b0;
  logic [2:0]  f1 = 3'd0;
  logic [31:0] a1 = 32'd0, d1 = 32'd0;
  logic        ready1, rv1, re1;
  logic [31:0] rd1;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqWrite(reqWrite), .reqFunct3(reqFunct3),
    .reqAddr(reqAddr), .reqWData(reqWData), .reqReady(reqReady), .respValid(respValid),
    .respRData(respRData), .respErr(respErr));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .reqValid(v1), .reqWrite(w1), .reqFunct3(f1),
    .reqAddr(a1), .reqWData(d1), .reqReady(ready1), .respValid(rv1),
    .respRData(rd1), .respErr(re1));

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] sbq1[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n1 = 0, first1 = -1, last1 = -1;
  logic [7:0] mdl [4*DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: byte-addressed memory, response computed from the access rules.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int sz;
    bit legal;
    longint v;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
    sz = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
    er = !legal || ((a % sz) != 0) || ((a / 4) >= DEPTH);
    rd = 32'd0;
    if (!er) begin
      if (wr) begin
        for (int i = 0; i < sz; i++) mdl[a + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++) v = v + (longint'(mdl[a + i]) << (8 * i));
        if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8 * sz));
        rd = v[31:0];
      end
    end
  endfunction

  // Present a request, wait (bounded) for acceptance, push the expected response.
  task automatic req(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input bit use_exp, input logic [31:0] exp_d, input logic exp_e, output int waited);
    exp_t e;
    logic [31:0] md;
    logic me;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = wr; reqFunct3 = f3; reqAddr = a; reqWData = wd;
    waited = 0;
    while (!reqReady && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady) begin
      chk("accept_timeout", 32'(reqReady), 32'd1);
      reqValid = 1'b0;
      return;
    end
    model(wr, f3, a, wd, md, me);
    e.data = use_exp ? exp_d : md;
    e.err  = use_exp ? exp_e : me;
    e.cyc  = cyc + LAT;
    sbq.push_back(e);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    reqValid = 1'b0;
  endtask

  // Scoreboard monitor for the LATENCY=2 instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst && respValid) begin
      if (sbq.size() == 0) begin
        chk("spurious_respValid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("respRData", respRData, e.data);
        chk("respErr", 32'(respErr), 32'(e.err));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Scoreboard monitor for the LATENCY=1 instance.
  always @(negedge clk) begin
    if (rst && rv1) begin
      n1++;
      if (first1 < 0) first1 = cyc;
      last1 = cyc;
      if (sbq1.size() == 0) begin
        chk("lat1_spurious_respValid", 32'd1, 32'd0);
      end else begin
        chk("lat1_respRData", rd1, sbq1.pop_front());
        chk("lat1_respErr", 32'(re1), 32'd0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int w;
    logic [31:0] vals [8];
    logic [2:0] rf3;
    logic [31:0] ra;

    for (int i = 0; i < 4*DEPTH; i++) mdl[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_reqReady", 32'(reqReady), 32'd0);
    chk("rst_respValid", 32'(respValid), 32'd0);
    chk("rst_respErr", 32'(respErr), 32'd0);
    chk("rst_respRData", respRData, 32'd0);
    rst = 1'b1;

    // Give the low region a known value (the array is not cleared by reset).
    for (int i = 0; i < 64; i++) req(1'b1, F3_W, 32'(4 * i), 32'd0, 1'b0, 32'd0, 1'b0, w);
    idle();
    repeat (4) @(negedge clk);

    // 1. Reset mid-WAIT drops the in-flight store.
    req(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, w);
    #2 rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < 4; i++) mdl[32'h10 + i] = 8'h00;
    reqValid = 1'b0;
    @(negedge clk);
    chk("rst2_respValid", 32'(respValid), 32'd0);
    chk("rst2_respErr", 32'(respErr), 32'd0);
    chk("rst2_respRData", respRData, 32'd0);
    chk("rst2_reqReady", 32'(reqReady), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req(1'b0, F3_W, 32'h10, 32'd0, 1'b1, 32'h0000_0000, 1'b0, w);

    // 2. Latency
    req(1'b1, F3_W, 32'h20, 32'h12345678, 1'b1, 32'd0, 1'b0, w);
    idle();
    chk("ready_in_wait", 32'(reqReady), 32'd0);
    chk("valid_in_wait", 32'(respValid), 32'd0);
    req(1'b0, F3_W, 32'h20, 32'd0, 1'b1, 32'h12345678, 1'b0, w);

    // 3. Lanes
    req(1'b1, F3_B, 32'h21, 32'h80, 1'b1, 32'd0, 1'b0, w);
    req(1'b0, F3_W, 32'h20, 32'd0, 1'b1, 32'h12348078, 1'b0, w);
    req(1'b0, F3_B, 32'h21, 32'd0, 1'b1, 32'hFFFFFF80, 1'b0, w);
    req(1'b0, F3_BU, 32'h21, 32'd0, 1'b1, 32'h00000080, 1'b0, w);
    req(1'b0, F3_H, 32'h22, 32'd0, 1'b1, 32'h00001234, 1'b0, w);

    // 4. Errors keep memory unchanged
    req(1'b0, F3_W, 32'h22, 32'd0, 1'b1, 32'd0, 1'b1, w);
    req(1'b1, F3_H, 32'h23, 32'hFFFF, 1'b1, 32'd0, 1'b1, w);
    req(1'b0, F3_W, 32'(4 * DEPTH), 32'd0, 1'b1, 32'd0, 1'b1, w);
    req(1'b0, 3'b011, 32'h20, 32'd0, 1'b1, 32'd0, 1'b1, w);
    req(1'b1, F3_BU, 32'h20, 32'hFF, 1'b1, 32'd0, 1'b1, w);
    req(1'b0, F3_W, 32'h20, 32'd0, 1'b1, 32'h12348078, 1'b0, w);

    // 5. Back-to-back load presented in the store's RESP cycle
    req(1'b1, F3_W, 32'h40, 32'hCAFEF00D, 1'b1, 32'd0, 1'b0, w);
    idle();
    req(1'b0, F3_W, 32'h40, 32'd0, 1'b1, 32'hCAFEF00D, 1'b0, w);
    chk("b2b_accept_wait", 32'(w), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 300; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 15))
        0:       ra = 32'h1000 + 32'($urandom_range(0, 255));
        1:       ra = $urandom();
        default: ra = 32'($urandom_range(0, 255));
      endcase
      req(1'($urandom_range(0, 1)), rf3, ra, $urandom(), 1'b0, 32'd0, 1'b0, w);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    for (int t = 0; t < 50 && sbq.size() != 0; t++) @(negedge clk);
    chk("drain_lat2", 32'(sbq.size()), 32'd0);

    // 6. LATENCY=1: one request every cycle
    for (int i = 0; i < 8; i++) vals[i] = $urandom();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      v1 = 1'b1;
      f1 = F3_W;
      if (i < 8) begin
        w1 = 1'b1; a1 = 32'(4 * i); d1 = vals[i];
        sbq1.push_back(32'd0);
      end else begin
        w1 = 1'b0; a1 = 32'(4 * (i - 8)); d1 = 32'd0;
        sbq1.push_back(vals[i - 8]);
      end
      chk("lat1_reqReady", 32'(ready1), 32'd1);
    end
    @(negedge clk);
    v1 = 1'b0;
    for (int t = 0; t < 20 && sbq1.size() != 0; t++) @(negedge clk);
    chk("drain_lat1", 32'(sbq1.size()), 32'd0);
    chk("lat1_count", 32'(n1), 32'd16);
    chk("lat1_span", 32'(last1 - first1), 32'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
